// File: rtl/multimode_game_counter_pkg.sv
// game_counter_pkg: shared state, mode and who encodings for the multi-mode game counter
package game_counter_pkg;
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    typedef enum logic [1:0] {INC_S, INC_L, DEC_S, DEC_L} mode_t;
    localparam logic [1:0] WHO_NONE   = 2'b00;
    localparam logic [1:0] WHO_LOSER  = 2'b01;
    localparam logic [1:0] WHO_WINNER = 2'b10;
endpackage

// File: rtl/score_counter.sv
// score_counter: saturating score with sync clear and a flag for the increment that reaches the limit
module score_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 15
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_limit
);
    assign at_limit = inc && count == W'(LIMIT - 1);
    // score register; clear wins over increment, never counts past the limit
    always_ff @(posedge clk) begin
        if (clr) count <= '0;
        else if (inc && count != W'(LIMIT)) count <= count + 1'b1;
    end
endmodule

// File: rtl/multimode_game_counter.sv
// multimode_game_counter: up/down stepping counter that scores wins at all-ones and losses at zero
module multimode_game_counter
    import game_counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SCORE_W     = 4,
    parameter int SCORE_LIMIT = (1 << SCORE_W) - 1,
    parameter int STEP_SMALL  = 1,
    parameter int STEP_LARGE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [WIDTH-1:0]   initial_val,
    input  logic               en,
    input  logic [1:0]         ctrl,
    output logic [WIDTH-1:0]   counted_no,
    output logic               winner,
    output logic               loser,
    output logic [SCORE_W-1:0] win_count,
    output logic [SCORE_W-1:0] lose_count,
    output logic               gameover,
    output logic [1:0]         who
);
    state_t           state, state_n;
    mode_t            mode;
    logic [WIDTH-1:0] step, nxt, cnt_n, saved;
    logic             stepping, load, win_hit, lose_hit, clr, win_end, lose_end;

    assign mode = mode_t'(ctrl);

    // step arithmetic and scoring events; a win masks a simultaneous loss
    always_comb begin
        step     = (mode == INC_L || mode == DEC_L) ? WIDTH'(STEP_LARGE) : WIDTH'(STEP_SMALL);
        nxt      = (mode == INC_S || mode == INC_L) ? counted_no + step : counted_no - step;
        stepping = state == RUN && en;
        load     = state == IDLE && init;
        win_hit  = stepping && nxt == '1;
        lose_hit = stepping && nxt == '0 && !win_hit;
        clr      = rst || load || state == OVER;
    end

    score_counter #(.W(SCORE_W), .LIMIT(SCORE_LIMIT)) u_win (
        .clk(clk), .clr(clr), .inc(win_hit), .count(win_count), .at_limit(win_end)
    );

    score_counter #(.W(SCORE_W), .LIMIT(SCORE_LIMIT)) u_lose (
        .clk(clk), .clr(clr), .inc(lose_hit), .count(lose_count), .at_limit(lose_end)
    );

    // next state and next count: load in IDLE, step in RUN, reload from saved init in OVER
    always_comb begin
        state_n = state == IDLE ? (init ? RUN : IDLE) :
                  state == RUN  ? ((win_end || lose_end) ? OVER : RUN) : RUN;
        cnt_n   = load ? initial_val : state == OVER ? saved : stepping ? nxt : counted_no;
    end

    // state, count and registered event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counted_no <= '0;
            saved      <= '0;
            winner     <= 1'b0;
            loser      <= 1'b0;
            gameover   <= 1'b0;
            who        <= WHO_NONE;
        end else begin
            state      <= state_n;
            counted_no <= cnt_n;
            saved      <= load ? initial_val : saved;
            winner     <= win_hit;
            loser      <= lose_hit;
            gameover   <= win_end || lose_end;
            who        <= win_end ? WHO_WINNER : lose_end ? WHO_LOSER : WHO_NONE;
        end
    end
endmodule

// File: doc/multimode_game_counter.md
# multimode_game_counter

Parametrised successor to the 4-bit multi-mode game counter. A WIDTH-bit up/down counter steps by a small or large increment each enabled cycle, selected by `ctrl`. Reaching all-ones scores a win and reaching zero scores a loss. When either score reaches `SCORE_LIMIT`, the block pulses `gameover`, reports the side in `who`, reloads the latched initial value and starts a new round. The block sits behind the game-control interface and is fully synchronous: one clock, no asynchronous paths.

## Interface
Parameters:
- `WIDTH`, 4: counter width; counting is modulo 2^WIDTH.
- `SCORE_W`, 4: width of the win and loss score counters.
- `SCORE_LIMIT`, 2^SCORE_W-1: score value that ends a game; legal range 1..2^SCORE_W-1.
- `STEP_SMALL`, 1: increment/decrement for `ctrl` 00/10; must be < 2^WIDTH.
- `STEP_LARGE`, 2: increment/decrement for `ctrl` 01/11; must be < 2^WIDTH.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `init`  in  1  load request; honoured only in IDLE.
- `initial_val`  in  WIDTH  value loaded by `init`; latched internally as the round start value.
- `en`  in  1  count enable for RUN; when low, the count holds.
- `ctrl`  in  2  mode: 00 +SMALL, 01 +LARGE, 10 -SMALL, 11 -LARGE.
- `counted_no`  out  WIDTH  current count.
- `winner`  out  1  high for the cycle in which a step has just produced all-ones.
- `loser`  out  1  high for the cycle in which a step has just produced zero.
- `win_count`, `lose_count`  out  SCORE_W  current scores.
- `gameover`  out  1  one-cycle pulse while in OVER.
- `who`  out  2  00 none, 01 loser side, 10 winner side; non-zero only while `gameover`=1.

## Operation
- States: IDLE, RUN, OVER.
- Reset (any state): IDLE; `counted_no`=0; saved init=0; both scores 0; `winner`=`loser`=`gameover`=0; `who`=00.
- IDLE:
  - `init`=1: `counted_no`<=`initial_val`; saved init<=`initial_val`; scores cleared; go to RUN.
  - `init`=0: stay in IDLE; `ctrl` and `en` are ignored.
- RUN with `en`=1: `counted_no`<=`counted_no`±step, truncated to WIDTH bits (wraps both ways).
  - `winner` is registered as (next == all-ones); `win_count` increments on that edge.
  - `loser` is registered as (next == 0); `lose_count` increments on that edge.
- RUN with `en`=0: count and scores hold; `winner`=`loser`=0.
- `init` in RUN or OVER is ignored. A new initial value requires `rst` followed by `init`.
- A load never scores. A loaded value of 0 or all-ones raises neither `winner` nor `loser`.
- Steps skipping over all-ones or zero do not score. Example: 14+2 wraps to 0 and scores a loss only.
- End of game: on the scoring edge where a score reaches `SCORE_LIMIT`, go to OVER and set `gameover`=1.
  - `who`=10 for a win, 01 for a loss.
  - The score shows `SCORE_LIMIT` during OVER.
  - Win and loss cannot score on the same edge. If they ever did, win takes priority.
- OVER (one cycle): `counted_no`<=saved init; scores<=0; `gameover`<=0; `who`<=00; go to RUN. `en` is ignored in OVER.
- Scores never exceed `SCORE_LIMIT`.

## Timing
- Load: `init` sampled at edge t in IDLE; `counted_no`=`initial_val` is visible after t. The first step is applied at edge t+1 if `en`=1.
- Step latency: one cycle. `winner`/`loser` assert in the same cycle as the new count value.
- Game end: the final scoring edge k raises `gameover`/`who` together with `winner` or `loser`. Edge k+1 reloads, clears and drops `gameover`. The first new step is applied at edge k+2.
- `rst` has priority over all other inputs on every edge, including mid-round and during OVER.

## Structure
- Package `game_counter_pkg`:
  - state enum {IDLE, RUN, OVER};
  - `ctrl` mode enum (INC_S, INC_L, DEC_S, DEC_L);
  - `who` constants WHO_NONE=2'b00, WHO_LOSER=2'b01, WHO_WINNER=2'b10.
- Sub-module `score_counter`, instantiated twice (win, loss): SCORE_W-bit counter with sync clear, increment and `at_limit` flag.

## Test plan
- `rst`, then `init`=1 with `initial_val`=14, `ctrl`=00, `en`=1 -> count 14, then 15 with `winner`=1 and `win_count`=1, then 0 with `loser`=1 and `lose_count`=1.
- Load 14, `ctrl`=01 -> next count 0, `loser`=1, `winner` never asserted; `ctrl`=11 from 1 -> 15, `winner`=1.
- Load 5, toggle `en` low for 3 cycles and pulse `init` mid-RUN -> count holds at its value, no score change, `init` has no effect.
- Load 13, `ctrl`=01, `en`=1 -> 15th win on step 113 with `gameover`=1 and `who`=10 for one cycle; next cycle count=13, scores 0; counting resumes the cycle after.
- `SCORE_LIMIT`=3, load 2, `ctrl`=10 -> third loss raises `gameover` with `who`=01, then reload to 2.
- Assert `rst` during OVER and mid-RUN -> next cycle IDLE with all outputs 0; no count until `init`.
